// File: rtl/flash_responder.sv
`default_nettype none
// =============================================================================
// Module  : flash_responder
// Brief   : x8 NOR flash chip model (StrataFlash command subset, one erase block)
//           Optional CFI query mode enabled by FLASH_RESP_CFI_EN.
// Revision: 1.0
// =============================================================================
module flash_responder #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter int                PROG_CYCLES  = 8,
  parameter int                ERASE_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERASED       = 8'hFF
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              NF_CE,
  input  logic              NF_BYTE,
  input  logic              NF_OE,
  input  logic              NF_RP,
  input  logic              NF_WE,
  input  logic              NF_WP,
  output logic              NF_STS,
  input  logic [ADDR_W-1:0] NF_A,
  inout  wire  [DATA_W-1:0] NF_D
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int MAX_CYC  = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int ST_READY = 7;
  localparam int ST_ERASE = 5;
  localparam int ST_PGM   = 4;
  localparam int ST_PROT  = 1;
  localparam logic [DATA_W-1:0] STATUS_IDLE = DATA_W'(8'h80);
  localparam logic [CNT_W-1:0]  PROG_LOAD   = CNT_W'(PROG_CYCLES);
  localparam logic [CNT_W-1:0]  ERASE_LOAD  = CNT_W'(ERASE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    READ_ARRAY, READ_STATUS, PROG_SETUP, ERASE_SETUP,
    PROG_BUSY, ERASE_BUSY, READ_QUERY
  } mode_t;

  logic [DATA_W-1:0] mem [DEPTH];
  mode_t             mode, mode_nxt;
  logic [DATA_W-1:0] status, status_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sts_nxt;
  logic [ADDR_W-1:0] pa, pa_nxt;
  logic [DATA_W-1:0] pd, pd_nxt;
  logic              we_q;
  logic              do_prog, do_erase;
  logic              wr_evt, busy, drive_en;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        cmd;
  logic              unused_byte;

  assign unused_byte = NF_BYTE;
  assign cmd         = NF_D[7:0];
  assign busy        = (mode == PROG_BUSY) || (mode == ERASE_BUSY);
  assign wr_evt      = !we_q && NF_WE && !NF_CE && NF_RP;
  assign drive_en    = !NF_CE && !NF_OE && NF_WE && NF_RP;

  always_comb begin
    mode_nxt   = mode;
    status_nxt = status;
    cnt_nxt    = cnt;
    sts_nxt    = NF_STS;
    pa_nxt     = pa;
    pd_nxt     = pd;
    do_prog    = 1'b0;
    do_erase   = 1'b0;
    // Power-down wins over everything, including a completing operation.
    if (!NF_RP) begin
      mode_nxt   = READ_ARRAY;
      status_nxt = STATUS_IDLE;
      cnt_nxt    = '0;
      sts_nxt    = 1'b1;
    end else if (busy) begin
      cnt_nxt = cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        do_prog              = (mode == PROG_BUSY);
        do_erase             = (mode == ERASE_BUSY);
        status_nxt[ST_READY] = 1'b1;
        sts_nxt              = 1'b1;
        mode_nxt             = READ_STATUS;
      end
    end else if (wr_evt) begin
      case (mode)
        PROG_SETUP: begin
          if (!NF_WP) begin
            status_nxt[ST_PGM]  = 1'b1;
            status_nxt[ST_PROT] = 1'b1;
            mode_nxt            = READ_STATUS;
          end else begin
            pa_nxt               = NF_A;
            pd_nxt               = NF_D;
            status_nxt[ST_READY] = 1'b0;
            sts_nxt              = 1'b0;
            cnt_nxt              = PROG_LOAD;
            mode_nxt             = PROG_BUSY;
          end
        end
        ERASE_SETUP: begin
          mode_nxt = READ_STATUS;
          if (cmd == 8'hD0 && NF_WP) begin
            status_nxt[ST_READY] = 1'b0;
            sts_nxt              = 1'b0;
            cnt_nxt              = ERASE_LOAD;
            mode_nxt             = ERASE_BUSY;
          end else if (cmd == 8'hD0) begin
            status_nxt[ST_ERASE] = 1'b1;
            status_nxt[ST_PROT]  = 1'b1;
          end else begin
            status_nxt[ST_ERASE] = 1'b1;
            status_nxt[ST_PGM]   = 1'b1;
          end
        end
        default: begin
          case (cmd)
            8'hFF: mode_nxt = READ_ARRAY;
            8'h70: mode_nxt = READ_STATUS;
            8'h50: begin
              status_nxt[ST_ERASE] = 1'b0;
              status_nxt[ST_PGM]   = 1'b0;
              status_nxt[ST_PROT]  = 1'b0;
              mode_nxt             = READ_STATUS;
            end
            8'h40, 8'h10: mode_nxt = PROG_SETUP;
            8'h20:        mode_nxt = ERASE_SETUP;
`ifdef FLASH_RESP_CFI_EN
            8'h98:        mode_nxt = READ_QUERY;
`endif
            default: begin
              status_nxt[ST_ERASE] = 1'b1;
              status_nxt[ST_PGM]   = 1'b1;
              mode_nxt             = READ_STATUS;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      mode   <= READ_ARRAY;
      status <= STATUS_IDLE;
      cnt    <= '0;
      NF_STS <= 1'b1;
      pa     <= '0;
      pd     <= '0;
      we_q   <= 1'b1;
    end else begin
      mode   <= mode_nxt;
      status <= status_nxt;
      cnt    <= cnt_nxt;
      NF_STS <= sts_nxt;
      pa     <= pa_nxt;
      pd     <= pd_nxt;
      we_q   <= NF_WE;
    end
  end

  // Programming can only clear bits; only erase sets them back.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ERASED;
    end else if (do_erase) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ERASED;
    end else if (do_prog) begin
      mem[pa] <= mem[pa] & pd;
    end
  end

  always_comb begin
    rd_data = status;
    if (mode == READ_ARRAY) begin
      rd_data = mem[NF_A];
    end
`ifdef FLASH_RESP_CFI_EN
    else if (mode == READ_QUERY) begin
      case (NF_A)
        ADDR_W'(16'h10): rd_data = DATA_W'(8'h51);
        ADDR_W'(16'h11): rd_data = DATA_W'(8'h52);
        ADDR_W'(16'h12): rd_data = DATA_W'(8'h59);
        default:         rd_data = '0;
      endcase
    end
`endif
  end

  assign NF_D = drive_en ? rd_data : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_flash_responder.sv
`default_nettype none
// =============================================================================
// Module  : tb_flash_responder
// Brief   : randomized bench for flash_responder against a timing-level model
// Revision: 1.0
// =============================================================================
module tb_flash_responder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int PC = 8;
  localparam int EC = 64;
  localparam int M_RA = 0, M_RS = 1, M_PS = 2, M_ES = 3, M_RQ = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic ce = 1'b1, byte_n = 1'b0, oe = 1'b1, rp = 1'b1, we = 1'b1, wp = 1'b1;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] drv_d = '0;
  logic den = 1'b0;
  wire sts;
  wire [DW-1:0] d_bus;

  assign d_bus = den ? drv_d : {DW{1'bz}};
  // Undriven bus reads as zero so a released bus is observable.
  for (genvar gi = 0; gi < DW; gi++) begin : g_pd
    pulldown (d_bus[gi]);
  end

  flash_responder #(.ADDR_W(AW), .DATA_W(DW), .PROG_CYCLES(PC),
                    .ERASE_CYCLES(EC), .ERASED(8'hFF)) dut (
    .CLK_50MHZ(clk), .RST(rst_n), .NF_CE(ce), .NF_BYTE(byte_n), .NF_OE(oe),
    .NF_RP(rp), .NF_WE(we), .NF_WP(wp), .NF_STS(sts), .NF_A(a), .NF_D(d_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int last_evt = 0;
  bit chk_on = 1'b0;

  // Model: array contents, read mode, sticky errors, and a pending operation
  // that completes at an absolute clock-edge index.
  logic [7:0] mmem [256];
  int mmode, bend;
  bit e5, e4, e1, pend, pkind;
  logic [7:0] pa_m, pd_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mstat(input bit ready);
    return {ready, 1'b0, e5, e4, 2'b00, e1, 1'b0};
  endfunction

  function automatic logic [7:0] cfi(input logic [7:0] addr);
    case (addr)
      8'h10: return 8'h51;
      8'h11: return 8'h52;
      8'h12: return 8'h59;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mmem[i] = 8'hFF;
    mmode = M_RA; e5 = 0; e4 = 0; e1 = 0; pend = 0; pkind = 0; bend = 0;
  endfunction

  function automatic void settle(input int c);
    if (pend && c >= bend) begin
      if (pkind == 1'b0) mmem[pa_m] = mmem[pa_m] & pd_m;
      else for (int i = 0; i < 256; i++) mmem[i] = 8'hFF;
      pend  = 0;
      mmode = M_RS;
    end
  endfunction

  function automatic void model_write(input int e, input logic [7:0] ad, input logic [7:0] d, input logic wpv);
    if (pend && e <= bend) return;
    settle(e);
    case (mmode)
      M_PS: begin
        mmode = M_RS;
        if (!wpv) begin e4 = 1; e1 = 1; end
        else begin pend = 1; pkind = 0; pa_m = ad; pd_m = d; bend = e + PC; end
      end
      M_ES: begin
        mmode = M_RS;
        if (d == 8'hD0 && wpv) begin pend = 1; pkind = 1; bend = e + EC; end
        else if (d == 8'hD0) begin e5 = 1; e1 = 1; end
        else begin e5 = 1; e4 = 1; end
      end
      default: begin
        case (d)
          8'hFF: mmode = M_RA;
          8'h70: mmode = M_RS;
          8'h50: begin e5 = 0; e4 = 0; e1 = 0; mmode = M_RS; end
          8'h40, 8'h10: mmode = M_PS;
          8'h20: mmode = M_ES;
`ifdef FLASH_RESP_CFI_EN
          8'h98: mmode = M_RQ;
`endif
          default: begin e5 = 1; e4 = 1; mmode = M_RS; end
        endcase
      end
    endcase
  endfunction

  function automatic void model_abort(input int e);
    if (pend && e <= bend) pend = 0;
    else settle(e);
    mmode = M_RA; e5 = 0; e4 = 0; e1 = 0;
  endfunction

  function automatic logic [7:0] exp_bus();
    if (!(ce == 1'b0 && oe == 1'b0 && we == 1'b1 && rp == 1'b1)) return 8'h00;
    if (pend) return mstat(1'b0);
    case (mmode)
      M_RA:    return mmem[a];
      M_RQ:    return cfi(a);
      default: return mstat(1'b1);
    endcase
  endfunction

  initial begin
    wait (chk_on);
    forever begin
      @(posedge clk);
      #2;
      settle(cyc);
      check("sts_model", sts, !pend);
      if (!den) check("bus_model", d_bus, exp_bus());
    end
  end

  task automatic wr(input logic [7:0] addr, input logic [7:0] dat);
    @(posedge clk); #1;
    ce = 0; oe = 1; a = addr; drv_d = dat; den = 1; we = 0;
    @(posedge clk); #1;
    we = 1;
    @(posedge clk); #1;
    last_evt = cyc;
    model_write(cyc, addr, dat, wp);
    ce = 1; den = 0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] v);
    @(posedge clk); #1;
    ce = 0; oe = 0; a = addr;
    #2;
    v = d_bus;
    oe = 1; ce = 1;
  endtask

  task automatic wait_ready(input string name, input int exp_len);
    int n = 0;
    while (sts == 1'b0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, cyc - last_evt, exp_len);
  endtask

  task automatic rp_pulse();
    @(posedge clk); #1;
    rp = 0;
    @(posedge clk); #1;
    model_abort(cyc);
    check("abort_sts", sts, 1);
    rp = 1;
  endtask

  logic [7:0] v;
  logic [7:0] cmds [8] = '{8'hFF, 8'h70, 8'h50, 8'h40, 8'h10, 8'h20, 8'h98, 8'hD0};

  initial begin
    model_reset();
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_sts", sts, 1);
    rst_n = 1;
    chk_on = 1;

    rd(8'h35, v);  check("read_erased", v, 8'hFF);
    #1 check("hiz_oe", d_bus, 8'h00);

    wr(8'h00, 8'h40); wr(8'h35, 8'hC9);
    check("prog_busy", sts, 0);
    rd(8'h00, v);  check("busy_status", v, 8'h00);
    wait_ready("prog_len", PC);
    rd(8'h00, v);  check("ready_status", v, 8'h80);
    wr(8'h00, 8'hFF);
    rd(8'h35, v);  check("prog_data", v, 8'hC9);

    wr(8'h00, 8'h40); wr(8'h35, 8'h3F);
    wait_ready("prog2_len", PC);
    wr(8'h00, 8'hFF);
    rd(8'h35, v);  check("prog_and", v, 8'h09);
    wr(8'h00, 8'h20); wr(8'h00, 8'hD0);
    wait_ready("erase_len", EC);
    wr(8'h00, 8'hFF);
    rd(8'h35, v);  check("erase_data", v, 8'hFF);

    wr(8'h00, 8'h20); wr(8'h00, 8'h55);
    check("seq_err_sts", sts, 1);
    rd(8'h00, v);  check("seq_err_status", v, 8'hB0);
    wr(8'h00, 8'h50);
    rd(8'h00, v);  check("clear_status", v, 8'h80);

    wp = 0;
    wr(8'h00, 8'h40); wr(8'h10, 8'h00);
    check("wp_sts", sts, 1);
    rd(8'h00, v);  check("wp_status", v, 8'h92);
    wp = 1;
    wr(8'h00, 8'h50); wr(8'h00, 8'hFF);
    rd(8'h10, v);  check("wp_data", v, 8'hFF);

    wr(8'h00, 8'h40); wr(8'h22, 8'h5A);
    wait_ready("prog3_len", PC);
    wr(8'h00, 8'h20); wr(8'h00, 8'hD0);
    repeat (8) begin @(posedge clk); #1; end
    rp_pulse();
    rd(8'h22, v);  check("abort_keep", v, 8'h5A);
    wr(8'h00, 8'h70);
    rd(8'h00, v);  check("abort_status", v, 8'h80);

    wr(8'h00, 8'h98);
`ifdef FLASH_RESP_CFI_EN
    rd(8'h11, v);  check("cfi_q", v, 8'h52);
    wr(8'h00, 8'hFF);
`else
    rd(8'h11, v);  check("cfi_off", v, 8'hB0);
    wr(8'h00, 8'h50);
`endif

    for (int it = 0; it < 400; it++) begin
      logic [7:0] ra;
      ra = 8'($urandom_range(8'h08, 8'h17));
      case ($urandom_range(0, 9))
        0, 1, 2: wr(ra, ($urandom_range(0, 5) == 0) ? 8'($urandom) : cmds[$urandom_range(0, 7)]);
        3, 4:    wr(ra, ($urandom_range(0, 2) == 0) ? 8'hD0 : 8'($urandom));
        5, 6:    rd(ra, v);
        7:       repeat ($urandom_range(1, 70)) begin @(posedge clk); #1; end
        8:       wp = ($urandom_range(0, 3) != 0);
        default: if ($urandom_range(0, 3) == 0) rp_pulse();
      endcase
    end
    wp = 1;
    repeat (80) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
